pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded by reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, meaning the count of wrong-path fetch slots squashed after a redirect; legal range 1..7.
REQ-003 i_Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_Rst_n  input  1  reset; synchronous, active-low.
REQ-005 i_Stall  input  1  fetch/pipeline frozen this cycle.
REQ-006 i_Is_Branch  input  1  EX stage holds a conditional branch.
REQ-007 i_Branch  input  1  taken decision from branch_decision for the EX-stage branch.
REQ-008 i_Jump  input  1  EX stage holds JAL/JALR (unconditional).
REQ-009 i_Target  input  32  redirect target address from EX.
REQ-010 o_PC  output  32  current fetch address.
REQ-011 o_PC_Valid  output  1  o_PC is a legal fetch request.
REQ-012 o_Flush  output  1  squash the IF/ID contents this cycle.
REQ-013 o_Misalign  output  1  one-cycle pulse: accepted target had bit[1] set.

Function
REQ-014 Redirect request SHALL be req = i_Jump | (i_Is_Branch & i_Branch), computed combinationally.
REQ-015 The block SHALL implement the states RUN, HOLD and FLUSH, held in a registered state variable.
REQ-016 RUN, req=0, i_Stall=0: o_PC SHALL advance to o_PC+4 next cycle, wrapping from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-017 Any state other than HOLD, req=0, i_Stall=1: o_PC SHALL hold its value.
REQ-018 RUN, req=1, i_Stall=0: o_PC SHALL load {i_Target[31:2],2'b00} next cycle, and the state SHALL go to FLUSH with the counter loaded to FLUSH_CYCLES.
REQ-019 RUN, req=1, i_Stall=1: the block SHALL capture {i_Target[31:2],2'b00} into a pending register, hold o_PC, and go to HOLD.
REQ-020 In HOLD, req SHALL be ignored; o_PC SHALL hold while i_Stall=1.
REQ-021 In HOLD, when i_Stall=0, o_PC SHALL load the pending target next cycle, and the state SHALL go to FLUSH with the counter loaded to FLUSH_CYCLES.
REQ-022 o_Flush SHALL be 1 exactly while in HOLD or FLUSH, and 0 in RUN.
REQ-023 In FLUSH, req SHALL be masked, because those EX instructions are wrong-path.
REQ-024 In FLUSH, o_PC SHALL advance by 4 per unstalled cycle.
REQ-025 In FLUSH, the counter SHALL decrement only on cycles with i_Stall=0; at count 1 with i_Stall=0 the state SHALL return to RUN.
REQ-026 o_Misalign SHALL pulse for one cycle, registered, when a redirect is accepted (REQ-018 or REQ-019) with i_Target[1]=1. The redirect SHALL still proceed with the low bits cleared.
REQ-027 o_PC_Valid SHALL be 0 in the reset cycle and SHALL be 1 from the first cycle after i_Rst_n rises, in all states.
REQ-028 Counter width SHALL be 3 bits. FLUSH_CYCLES outside 1..7 SHALL be a compile-time error.

Reset
REQ-029 While i_Rst_n=0 at a clock edge, the next state SHALL be: o_PC=RESET_PC, o_PC_Valid=0, o_Flush=0, o_Misalign=0, state=RUN, counter=0, pending=0.
REQ-030 Reset SHALL override all inputs, including mid-HOLD and mid-FLUSH; a pending target SHALL be discarded.

Structure
REQ-031 State encodings (RUN=2'd0, HOLD=2'd1, FLUSH=2'd2) and the PC increment constant 32'd4 SHALL live in shared parameters.vh, alongside the existing branch func3 codes.
REQ-032 The block SHALL be a single module with no sub-modules. The adder and target alignment SHALL be inline.

Verification
REQ-033 Reset with RESET_PC=32'h0000_0100, then 3 unstalled cycles -> o_PC = 100,104,108,10C; o_PC_Valid=0 only in the reset cycle.
REQ-034 RUN, i_Is_Branch=1, i_Branch=1, i_Target=32'h0000_2000, no stall -> next o_PC=2000, o_Flush=1 for exactly 2 cycles (o_PC 2000, 2004), then 0 at o_PC 2008.
REQ-035 i_Stall=1 with i_Jump=1, i_Target=32'h0000_3000, stall held 3 cycles -> o_PC frozen and o_Flush=1 throughout; stall released -> o_PC=3000, then 2 flush cycles.
REQ-036 FLUSH with i_Jump=1, i_Target=32'h0000_4000 -> ignored; o_PC continues +4. Also i_Is_Branch=1 with i_Branch=0 in RUN -> no flush.
REQ-037 i_Jump=1, i_Target=32'h0000_5002 -> o_PC=5000, o_Misalign=1 for one cycle. Separately, o_PC=FFFF_FFFC with no stall -> next o_PC=0000_0000.
REQ-038 i_Rst_n=0 asserted mid-HOLD -> next cycle o_PC=RESET_PC, o_Flush=0, and the pending target is never loaded after reset release.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared fetch-unit constants, FSM encodings and branch func3 codes.
package pc_gen_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } pc_state_t;
    localparam logic [31:0] PC_INC = 32'd4;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with stall-safe redirects and wrong-path flush window.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Stall,
    input  logic        i_Is_Branch,
    input  logic        i_Branch,
    input  logic        i_Jump,
    input  logic [31:0] i_Target,
    output logic [31:0] o_PC,
    output logic        o_PC_Valid,
    output logic        o_Flush,
    output logic        o_Misalign
);
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
        $error("pc_gen: FLUSH_CYCLES must be in 1..7");
    end
    localparam logic [2:0] FC = 3'(FLUSH_CYCLES);
    pc_state_t   state, state_d;
    logic [2:0]  cnt, cnt_d;
    logic [31:0] pend, pend_d, pc_d, tgt, pc_inc;
    logic        req, mis_d;
    assign req     = i_Jump | (i_Is_Branch & i_Branch);
    assign tgt     = {i_Target[31:2], 2'b00};
    assign pc_inc  = o_PC + PC_INC;
    assign o_Flush = state != RUN;
    always_comb begin
        state_d = state;
        pc_d    = o_PC;
        cnt_d   = cnt;
        pend_d  = pend;
        mis_d   = 1'b0;
        case (state)
            RUN: begin
                if (req) begin
                    mis_d = i_Target[1];
                    if (i_Stall) begin
                        pend_d  = tgt;
                        state_d = HOLD;
                    end else begin
                        pc_d    = tgt;
                        cnt_d   = FC;
                        state_d = FLUSH;
                    end
                end else if (!i_Stall) begin
                    pc_d = pc_inc;
                end
            end
            HOLD: begin
                if (!i_Stall) begin
                    pc_d    = pend;
                    cnt_d   = FC;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // EX redirects here come from wrong-path instructions and are dropped
                if (!i_Stall) begin
                    pc_d    = pc_inc;
                    cnt_d   = cnt - 3'd1;
                    state_d = (cnt == 3'd1) ? RUN : FLUSH;
                end
            end
            default: state_d = RUN;
        endcase
    end
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state      <= RUN;
            o_PC       <= RESET_PC;
            o_PC_Valid <= 1'b0;
            o_Misalign <= 1'b0;
            cnt        <= 3'd0;
            pend       <= 32'd0;
        end else begin
            state      <= state_d;
            o_PC       <= pc_d;
            o_PC_Valid <= 1'b1;
            o_Misalign <= mis_d;
            cnt        <= cnt_d;
            pend       <= pend_d;
        end
    end
endmodule
